// File: rtl/parking_occupancy_tracker.sv
// Debounced parking-lot occupancy tracker: per-spot 2-flop sync + debounce,
// registered parked count, lot status flags and arrival/departure pulses.
module parking_occupancy_tracker #(
  parameter int NUM_SPOTS   = 8,
  parameter int DEBOUNCE    = 4,
  parameter int ALMOST_FULL = 6,
  localparam int CNT_W      = $clog2(NUM_SPOTS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_SPOTS-1:0] sensor,
  output logic [NUM_SPOTS-1:0] occupied,
  output logic [CNT_W-1:0]     parked_count,
  output logic [CNT_W-1:0]     free_count,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 arrive_pulse,
  output logic                 depart_pulse
);

  localparam int DBC_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(DEBOUNCE - 1);

  logic [NUM_SPOTS-1:0]             s1_q, s2_q;
  logic [NUM_SPOTS-1:0][DBC_W-1:0]  dbc_q, dbc_d;
  logic [NUM_SPOTS-1:0]             occ_q, occ_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             rise_q, rise_d, fall_q, fall_d;
  logic                             arrive_q, depart_q;

  always_comb begin
    dbc_d = dbc_q;
    occ_d = occ_q;
    if (en) begin
      for (int unsigned i = 0; i < NUM_SPOTS; i++) begin
        if (s2_q[i] == occ_q[i]) begin
          dbc_d[i] = '0;
        end else if (dbc_q[i] == DBC_MAX) begin
          occ_d[i] = s2_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < NUM_SPOTS; i++) begin
      cnt_d = cnt_d + CNT_W'(occ_q[i]);
    end
  end

  // Flip flags are captured on the flip edge and re-registered so the pulses
  // line up with parked_count, one edge after occupied changes.
  always_comb begin
    rise_d = |(occ_d & ~occ_q);
    fall_d = |(~occ_d & occ_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      dbc_q    <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      arrive_q <= 1'b0;
      depart_q <= 1'b0;
    end else begin
      s1_q     <= sensor;
      s2_q     <= s1_q;
      dbc_q    <= dbc_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      arrive_q <= rise_q;
      depart_q <= fall_q;
    end
  end

  always_comb begin
    occupied     = occ_q;
    parked_count = cnt_q;
    free_count   = CNT_W'(NUM_SPOTS) - cnt_q;
    full         = (cnt_q == CNT_W'(NUM_SPOTS));
    empty        = (cnt_q == '0);
    almost_full  = (32'(cnt_q) >= 32'(ALMOST_FULL));
    arrive_pulse = arrive_q;
    depart_pulse = depart_q;
  end

endmodule

// File: tb/tb_parking_occupancy_tracker.sv
// Scoreboard bench for parking_occupancy_tracker: a window-based reference
// model pushes expectations each edge, a negedge monitor pops and compares.
module tb_parking_occupancy_tracker;

  localparam int NS = 8;
  localparam int DB = 4;
  localparam int AF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] sensor;
  logic [7:0] occupied;
  logic [3:0] parked_count, free_count;
  logic       full, empty, almost_full, arrive_pulse, depart_pulse;

  parking_occupancy_tracker #(.NUM_SPOTS(NS), .DEBOUNCE(DB), .ALMOST_FULL(AF)) dut (
    .clk(clk), .rst(rst), .en(en), .sensor(sensor),
    .occupied(occupied), .parked_count(parked_count), .free_count(free_count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .arrive_pulse(arrive_pulse), .depart_pulse(depart_pulse)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] occ;
    logic [3:0] cnt;
    logic       arr;
    logic       dep;
  } exp_t;

  exp_t sb[$];

  // Reference model: sensor delayed two edges; a spot flips once its last DB
  // enabled-edge samples all disagree with the current occupancy.
  logic [7:0] m_s1 = '0, m_s2 = '0, m_occ = '0, m_rise = '0, m_fall = '0;
  logic [7:0] win[$];
  logic [7:0] nocc;
  exp_t       e;
  bit         all_diff;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_occ = '0; m_rise = '0; m_fall = '0;
      win.delete();
      e = '{occ: 8'h00, cnt: 4'd0, arr: 1'b0, dep: 1'b0};
    end else begin
      nocc = m_occ;
      if (en) begin
        win.push_back(m_s2);
        if (win.size() > DB) void'(win.pop_front());
        if (win.size() == DB) begin
          for (int b = 0; b < NS; b++) begin
            all_diff = 1'b1;
            foreach (win[j]) if (win[j][b] == m_occ[b]) all_diff = 1'b0;
            if (all_diff) nocc[b] = ~m_occ[b];
          end
        end
      end
      e.occ = nocc;
      e.cnt = 4'($countones(m_occ));
      e.arr = |m_rise;
      e.dep = |m_fall;
      m_rise = nocc & ~m_occ;
      m_fall = ~nocc & m_occ;
      m_occ  = nocc;
      m_s2   = m_s1;
      m_s1   = sensor;
    end
    sb.push_back(e);
  end

  exp_t got;
  always @(negedge clk) begin
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("occupied",     32'(occupied),     32'(got.occ));
      check("parked_count", 32'(parked_count), 32'(got.cnt));
      check("free_count",   32'(free_count),   32'(4'd8 - got.cnt));
      check("full",         32'(full),         32'(got.cnt == 4'd8));
      check("empty",        32'(empty),        32'(got.cnt == 4'd0));
      check("almost_full",  32'(almost_full),  32'(got.cnt >= 4'd6));
      check("arrive_pulse", 32'(arrive_pulse), 32'(got.arr));
      check("depart_pulse", 32'(depart_pulse), 32'(got.dep));
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset asserted just after a monitor sample, held across one edge.
  task automatic mid_reset(input bit check_now);
    #1 rst = 1'b1;
    if (check_now) begin
      #1;
      check("rst_occupied", 32'(occupied),     32'h00);
      check("rst_count",    32'(parked_count), 32'd0);
      check("rst_free",     32'(free_count),   32'd8);
      check("rst_empty",    32'(empty),        32'd1);
      check("rst_pulses",   32'({arrive_pulse, depart_pulse}), 32'd0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] mask;

  initial begin
    rst = 1'b1; en = 1'b1; sensor = 8'h00;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(3);

    // single arrival latency
    sensor = 8'h01;
    wait_neg(5);
    check("arr_pre_flip", 32'(occupied), 32'h00);
    wait_neg(1);
    check("arr_flip", 32'(occupied), 32'h01);
    wait_neg(1);
    check("arr_count", 32'(parked_count), 32'd1);
    check("arr_pulse", 32'(arrive_pulse), 32'd1);
    check("arr_empty", 32'(empty), 32'd0);
    wait_neg(1);
    check("arr_pulse_end", 32'(arrive_pulse), 32'd0);

    // glitch rejection, then acceptance
    wait_neg(2);
    sensor = 8'h09; wait_neg(3);
    sensor = 8'h01; wait_neg(8);
    check("glitch_rej", 32'(occupied), 32'h01);
    sensor = 8'h09; wait_neg(4);
    sensor = 8'h01; wait_neg(2);
    check("glitch_acc", 32'(occupied), 32'h09);
    wait_neg(10);

    // fill and flags
    sensor = 8'h3F; wait_neg(10);
    check("af_count", 32'(parked_count), 32'd6);
    check("af_flag",  32'(almost_full),  32'd1);
    check("af_full",  32'(full),         32'd0);
    sensor = 8'hFF; wait_neg(10);
    check("full_count", 32'(parked_count), 32'd8);
    check("full_free",  32'(free_count),   32'd0);
    check("full_flag",  32'(full),         32'd1);

    // simultaneous arrive/depart
    sensor = 8'h0F; wait_neg(10);
    check("sim_pre", 32'(occupied), 32'h0F);
    sensor = 8'hF0; wait_neg(7);
    check("sim_arr", 32'(arrive_pulse), 32'd1);
    check("sim_dep", 32'(depart_pulse), 32'd1);
    check("sim_cnt", 32'(parked_count), 32'd4);
    wait_neg(3);

    // reset mid-run with occupied = F0
    check("pre_rst_occ", 32'(occupied), 32'hF0);
    mid_reset(1'b1);

    // freeze
    en = 1'b0; sensor = 8'hFF; wait_neg(20);
    check("frz_hold", 32'(occupied), 32'h00);
    en = 1'b1; wait_neg(3);
    check("frz_pre", 32'(occupied), 32'h00);
    wait_neg(1);
    check("frz_rel", 32'(occupied), 32'hFF);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) mid_reset(1'b0);
      mask   = 8'($urandom & $urandom & $urandom);
      sensor = sensor ^ mask;
      en     = ($urandom_range(0, 9) != 0);
    end

    wait_neg(3);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
